sseg_rd: RTL and testbench

SSEG_RD -- requirements
Module: sseg_rd

---
 rtl/sseg_rd.sv | 161 ++++++++++++++++
 tb/tb_sseg_rd.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sseg_rd.sv
// sseg_rd: recovers hex digits from a multiplexed, active-low seven-segment bus.
// Optional macro SSEG_RD_ERR_CNT_EN adds a saturating 8-bit error counter (err_cnt_o).
module sseg_rd #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [6:0]            seg_i,
    input  logic [DIGITS-1:0]     an_i,
    output logic [4*DIGITS-1:0]   data_o,
    output logic [DIGITS-1:0]     digit_valid_o,
    output logic                  err_o,
    output logic                  frame_o
`ifdef SSEG_RD_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
    typedef enum logic [1:0] {K_HEX, K_BLANK, K_ERR} kind_t;

    localparam logic [DIGITS-1:0] ONE    = DIGITS'(1);
    localparam logic [7:0]        STABLE = 8'(STABLE_CYC);

    state_t              state;
    logic [7:0]          cnt;
    logic [DIGITS-1:0]   pair_an;
    logic [6:0]          pair_seg;
    logic [DIGITS-1:0]   mask;

    logic [DIGITS-1:0]   an_n;
    logic                one_hot;
    logic                same;
    logic                cap;
    logic [DIGITS-1:0]   sel;
    kind_t               kind;
    logic [3:0]          val;

    always_comb begin
        an_n    = ~an_i;
        one_hot = (an_n != '0) && ((an_n & (an_n - ONE)) == '0);
        same    = (an_i == pair_an) && (seg_i == pair_seg);
        cap     = (state == TRACK) && (cnt == STABLE);
        sel     = ~pair_an;
    end

    always_comb begin
        kind = K_HEX;
        val  = 4'h0;
        case (pair_seg)
            7'b0000001: val = 4'h0;
            7'b1001111: val = 4'h1;
            7'b0010010: val = 4'h2;
            7'b0000110: val = 4'h3;
            7'b1001100: val = 4'h4;
            7'b0100100: val = 4'h5;
            7'b0100000: val = 4'h6;
            7'b0001111: val = 4'h7;
            7'b0000000: val = 4'h8;
            7'b0000100: val = 4'h9;
            7'b0001000: val = 4'hA;
            7'b1100000: val = 4'hB;
            7'b0110001: val = 4'hC;
            7'b1000010: val = 4'hD;
            7'b0110000: val = 4'hE;
            7'b0111000: val = 4'hF;
            7'b1111110, 7'b1111111: kind = K_BLANK;
            default: kind = K_ERR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            pair_an       <= '1;
            pair_seg      <= 7'h7F;
            mask          <= '0;
            data_o        <= '0;
            digit_valid_o <= '0;
            err_o         <= 1'b0;
            frame_o       <= 1'b0;
`ifdef SSEG_RD_ERR_CNT_EN
            err_cnt_o     <= 8'd0;
`endif
        end else begin
            err_o   <= 1'b0;
            frame_o <= 1'b0;

            // The capture uses the stored pair, so it fires even if the bus moves on this edge.
            if (cap) begin
                for (int n = 0; n < DIGITS; n++) begin
                    if (sel[n]) begin
                        case (kind)
                            K_HEX: begin
                                data_o[4*n +: 4] <= val;
                                digit_valid_o[n] <= 1'b1;
                            end
                            K_BLANK: digit_valid_o[n] <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                err_o <= (kind == K_ERR);
                if ((mask | sel) == '1) begin
                    mask    <= '0;
                    frame_o <= 1'b1;
                end else begin
                    mask <= mask | sel;
                end
`ifdef SSEG_RD_ERR_CNT_EN
                if (kind == K_ERR && err_cnt_o != 8'hFF)
                    err_cnt_o <= err_cnt_o + 8'd1;
`endif
            end

            case (state)
                IDLE: begin
                    if (one_hot) begin
                        state    <= TRACK;
                        cnt      <= 8'd1;
                        pair_an  <= an_i;
                        pair_seg <= seg_i;
                    end
                end
                TRACK: begin
                    if (!one_hot) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (cap && same) begin
                        state <= HOLD;
                    end else if (!cap && same) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        cnt      <= 8'd1;
                        pair_an  <= an_i;
                        pair_seg <= seg_i;
                    end
                end
                HOLD: begin
                    if (!one_hot) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (!same) begin
                        state    <= TRACK;
                        cnt      <= 8'd1;
                        pair_an  <= an_i;
                        pair_seg <= seg_i;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_rd.sv
// Directed bench for sseg_rd (DIGITS=4, STABLE_CYC=4): per-edge expected outputs
// are queued as each edge is driven and checked just after that edge.
module tb_sseg_rd;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [6:0]  seg_i = 7'h7F;
    logic [3:0]  an_i  = 4'hF;
    logic [15:0] data_o;
    logic [3:0]  digit_valid_o;
    logic        err_o;
    logic        frame_o;
`ifdef SSEG_RD_ERR_CNT_EN
    logic [7:0]  err_cnt_o;
`endif

    sseg_rd #(.DIGITS(4), .STABLE_CYC(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .seg_i         (seg_i),
        .an_i          (an_i),
        .data_o        (data_o),
        .digit_valid_o (digit_valid_o),
        .err_o         (err_o),
        .frame_o       (frame_o)
`ifdef SSEG_RD_ERR_CNT_EN
        ,
        .err_cnt_o     (err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110, P5 = 7'b0100100, P6 = 7'b0100000;
    localparam logic [6:0] P8 = 7'b0000000, PA = 7'b0001000, PF = 7'b0111000;
    localparam logic [6:0] DASH = 7'b1111110, BLANK = 7'b1111111, BAD = 7'b1010101;

    logic [21:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    logic [15:0] e_data  = '0;
    logic [3:0]  e_valid = '0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One edge: drive inputs, queue the outputs expected after the edge, then compare.
    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic rst,
                         input logic [15:0] d, input logic [3:0] v,
                         input logic e, input logic f);
        logic [21:0] exp_v;
        @(negedge clk_i);
        an_i  = an;
        seg_i = seg;
        rst_i = rst;
        exp_q.push_back({d, v, e, f});
        @(posedge clk_i);
        #1;
        exp_v = exp_q.pop_front();
        check("data",  data_o,                 exp_v[21:6]);
        check("valid", {12'd0, digit_valid_o}, {12'd0, exp_v[5:2]});
        check("err",   {15'd0, err_o},         {15'd0, exp_v[1]});
        check("frame", {15'd0, frame_o},       {15'd0, exp_v[0]});
    endtask

    // n edges of one pair; the first edge carries the given expectation (a capture
    // from the previous dwell, if any), the rest expect quiet, unchanged outputs.
    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n,
                         input logic [15:0] d, input logic [3:0] v,
                         input logic e, input logic f);
        e_data  = d;
        e_valid = v;
        drive(an, seg, 1'b0, d, v, e, f);
        for (int i = 1; i < n; i++)
            drive(an, seg, 1'b0, e_data, e_valid, 1'b0, 1'b0);
    endtask

    initial begin
        // reset state
        drive(4'hF, BLANK, 1'b1, 16'h0, 4'h0, 1'b0, 1'b0);
        drive(4'hE, P2,    1'b1, 16'h0, 4'h0, 1'b0, 1'b0);

        // single digit capture on the 5th edge, then a long hold with no recapture
        dwell(4'hE, P2, 4,  16'h0000, 4'b0000, 1'b0, 1'b0);
        dwell(4'hE, P2, 20, 16'h0002, 4'b0001, 1'b0, 1'b0);

        // scan 1, A, 0, F; each capture lands on the first edge of the next dwell
        dwell(4'hE, P1, 4, 16'h0002, 4'b0001, 1'b0, 1'b0);
        dwell(4'hD, PA, 4, 16'h0001, 4'b0001, 1'b0, 1'b0);
        dwell(4'hB, P0, 4, 16'h00A1, 4'b0011, 1'b0, 1'b0);
        dwell(4'h7, PF, 4, 16'h00A1, 4'b0111, 1'b0, 1'b0);
        dwell(4'hF, BLANK, 3, 16'hF0A1, 4'b1111, 1'b0, 1'b1);

        // unrecognised pattern on digit 1
        dwell(4'hD, BAD, 4,  16'hF0A1, 4'b1111, 1'b0, 1'b0);
        dwell(4'hF, BLANK, 2, 16'hF0A1, 4'b1111, 1'b1, 1'b0);
`ifdef SSEG_RD_ERR_CNT_EN
        check("err_cnt_1", {8'd0, err_cnt_o}, 16'd1);
`endif

        // 8 interrupted after 3 edges by a dash: blank capture only
        dwell(4'hB, P8, 3,   16'hF0A1, 4'b1111, 1'b0, 1'b0);
        dwell(4'hB, DASH, 4, 16'hF0A1, 4'b1111, 1'b0, 1'b0);
        dwell(4'hF, BLANK, 2, 16'hF0A1, 4'b1011, 1'b0, 1'b0);

        // two anodes low never capture
        dwell(4'hC, P8, 10, 16'hF0A1, 4'b1011, 1'b0, 1'b0);

        // reset mid-dwell discards the partial count
        dwell(4'hE, P3, 2, 16'hF0A1, 4'b1011, 1'b0, 1'b0);
        drive(4'hE, P3, 1'b1, 16'h0, 4'h0, 1'b0, 1'b0);
        dwell(4'hE, P3, 4, 16'h0000, 4'b0000, 1'b0, 1'b0);
        dwell(4'hE, P3, 2, 16'h0003, 4'b0001, 1'b0, 1'b0);

        // frame completed by an error capture: err and frame together
        dwell(4'hD, P5, 4,  16'h0003, 4'b0001, 1'b0, 1'b0);
        dwell(4'hB, P6, 4,  16'h0053, 4'b0011, 1'b0, 1'b0);
        dwell(4'h7, BAD, 4, 16'h0653, 4'b0111, 1'b0, 1'b0);
        dwell(4'hF, BLANK, 2, 16'h0653, 4'b0111, 1'b1, 1'b1);
`ifdef SSEG_RD_ERR_CNT_EN
        check("err_cnt_2", {8'd0, err_cnt_o}, 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
